// File: rtl/mem_seq_initiator_pkg.sv
// -----------------------------------------------------------------------------
// mem_seq_initiator_pkg
//
// Shared definitions for the memory sequence initiator:
//   - state_t      : sequencer states, in issue order
//   - mem_ctrl_t   : data-phase encodings ([1] read, [0] write)
//   - seq_req_t    : one instruction's request, latched at accept
//   - reg_addr()   : byte address of a register-file word
//   - next_stage() : next non-skipped state once an access completes
// -----------------------------------------------------------------------------
package mem_seq_initiator_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_RS1   = 3'd2,
        S_RS2   = 3'd3,
        S_DMEM  = 3'd4,
        S_WB    = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        MC_NONE = 2'b00,
        MC_WR   = 2'b01,
        MC_RD   = 2'b10,
        MC_ERR  = 2'b11
    } mem_ctrl_t;

    typedef struct packed {
        logic [31:0] ins_addr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        op_write;
        logic [31:0] wb_value;
        mem_ctrl_t   mc;
        logic [31:0] address;
        logic [31:0] w_data;
    } seq_req_t;

    // Register file words sit at base + 4*index.
    function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [4:0] idx);
        return base + {25'd0, idx, 2'b00};
    endfunction

    function automatic state_t after_dmem(input seq_req_t r);
        return (r.op_write && (r.rd != 5'd0)) ? S_WB : S_DONE;
    endfunction

    // Decision once the register reads are out of the way. An illegal
    // mem_ctrl goes straight to DONE and also bypasses write-back.
    function automatic state_t after_regs(input seq_req_t r);
        state_t n;
        case (r.mc)
            MC_RD, MC_WR: n = S_DMEM;
            MC_ERR:       n = S_DONE;
            default:      n = after_dmem(r);
        endcase
        return n;
    endfunction

    // Skipped stages cost no cycle: jump straight to the next real access.
    function automatic state_t next_stage(input state_t s, input seq_req_t r);
        state_t n;
        case (s)
            S_FETCH: n = (r.rs1 != 5'd0) ? S_RS1 :
                         (r.rs2 != 5'd0) ? S_RS2 : after_regs(r);
            S_RS1:   n = (r.rs2 != 5'd0) ? S_RS2 : after_regs(r);
            S_RS2:   n = after_regs(r);
            S_DMEM:  n = after_dmem(r);
            default: n = S_DONE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_seq_initiator_if.sv
// -----------------------------------------------------------------------------
// mem_seq_initiator_if
//
// Single shared word port between the initiator and the unified memory.
//   mem_req   : access request (initiator -> memory)
//   mem_we    : write strobe
//   mem_addr  : byte address, held stable while mem_req=1
//   mem_wdata : write data, held stable while mem_req=1
//   mem_rdata : read data, valid while mem_ready=1
//   mem_ready : access completes on an edge with mem_req=1 and mem_ready=1
// -----------------------------------------------------------------------------
interface mem_seq_initiator_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_seq_watchdog.sv
// -----------------------------------------------------------------------------
// mem_seq_watchdog
//
// Per-access wait counter, only present when MEM_SEQ_TIMEOUT_EN is defined.
//   clk, reset_n : clock, asynchronous active-low reset
//   mem_req      : an access is outstanding
//   mem_ready    : memory completes the access this cycle
//   expired      : this is the TIMEOUT-th wait cycle; abandon the access
// The count clears whenever no access is waiting, so each new access
// starts from zero.
// -----------------------------------------------------------------------------
`ifdef MEM_SEQ_TIMEOUT_EN
module mem_seq_watchdog #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic mem_req,
    input  logic mem_ready,
    output logic expired
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt;

    assign expired = mem_req && !mem_ready && (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (!mem_req || mem_ready || expired) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
endmodule
`endif

// File: rtl/mem_seq_initiator.sv
// -----------------------------------------------------------------------------
// mem_seq_initiator
//
// Sequences one instruction's memory traffic (fetch, rs1 read, rs2 read,
// data read/write, register write-back) onto one shared word port and holds
// the core busy until the sequence finishes.
//
// Ports:
//   clk, reset_n           : clock, asynchronous active-low reset
//   cyc_valid              : start request, sampled only in IDLE
//   ins_addr               : fetch byte address
//   rs1_addr, rs2_addr     : source register indices (0 = no read, value 0)
//   rd_addr, op_write      : write-back index / enable
//   wb_value               : write-back data
//   mem_ctrl               : [1] data read, [0] data write (11 = error)
//   address, w_data        : data byte address / write value
//   mem                    : memory port (master modport)
//   ins_data, rs1_value,
//   rs2_value, read_data   : registered results
//   cyc_done               : one-cycle pulse in DONE
//   busy                   : state != IDLE
//   err                    : sticky error, cleared on accept
//
// Build option: MEM_SEQ_TIMEOUT_EN adds a per-access watchdog that abandons
// an access after TIMEOUT wait cycles and finishes the sequence with err=1.
// -----------------------------------------------------------------------------
module mem_seq_initiator
    import mem_seq_initiator_pkg::*;
#(
    parameter logic [31:0] REG_BASE = 32'd0,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       cyc_valid,
    input  logic [31:0]                ins_addr,
    input  logic [4:0]                 rs1_addr,
    input  logic [4:0]                 rs2_addr,
    input  logic [4:0]                 rd_addr,
    input  logic                       op_write,
    input  logic [31:0]                wb_value,
    input  logic [1:0]                 mem_ctrl,
    input  logic [31:0]                address,
    input  logic [31:0]                w_data,
    mem_seq_initiator_if.master        mem,
    output logic [31:0]                ins_data,
    output logic [31:0]                rs1_value,
    output logic [31:0]                rs2_value,
    output logic [31:0]                read_data,
    output logic                       cyc_done,
    output logic                       busy,
    output logic                       err
);

    state_t   state;
    state_t   state_nxt;
    seq_req_t req_q;
    logic     accept;
    logic     access_done;
    logic     timeout;

    assign accept      = (state == S_IDLE) && cyc_valid;
    assign access_done = mem.mem_req && mem.mem_ready;

`ifdef MEM_SEQ_TIMEOUT_EN
    mem_seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .reset_n   (reset_n),
        .mem_req   (mem.mem_req),
        .mem_ready (mem.mem_ready),
        .expired   (timeout)
    );
`else
    // Without the watchdog accesses wait indefinitely.
    logic unused_cfg;
    assign unused_cfg = |TIMEOUT;
    assign timeout    = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create ordering-dependent races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    // NOTE: every always_comb output gets a default on entry; a path that
    // leaves it unassigned would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cyc_valid) state_nxt = S_FETCH;
            end
            S_FETCH, S_RS1, S_RS2, S_DMEM, S_WB: begin
                if (timeout) begin
                    state_nxt = S_DONE;
                end else if (access_done) begin
                    state_nxt = next_stage(state, req_q);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs: decoded from state and the latched request, so they fall to
    // zero the instant reset forces IDLE and cannot move during an access.
    // ---------------------------------------------------------------------
    always_comb begin
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = 32'd0;
        mem.mem_wdata = 32'd0;
        case (state)
            S_FETCH: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = req_q.ins_addr;
            end
            S_RS1: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = reg_addr(REG_BASE, req_q.rs1);
            end
            S_RS2: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = reg_addr(REG_BASE, req_q.rs2);
            end
            S_DMEM: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = req_q.address;
                if (req_q.mc == MC_WR) begin
                    mem.mem_we    = 1'b1;
                    mem.mem_wdata = req_q.w_data;
                end
            end
            S_WB: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = reg_addr(REG_BASE, req_q.rd);
                mem.mem_wdata = req_q.wb_value;
            end
            default: ;
        endcase
    end

    assign cyc_done = (state == S_DONE);
    assign busy     = (state != S_IDLE);

    // ---------------------------------------------------------------------
    // Request latch, result registers and error flag
    // ---------------------------------------------------------------------
    // NOTE: these registers are architecturally visible and must read 0
    // after reset (a reset mid-sequence discards partial results), so they
    // all take the asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q     <= '0;
            ins_data  <= 32'd0;
            rs1_value <= 32'd0;
            rs2_value <= 32'd0;
            read_data <= 32'd0;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                req_q <= '{
                    ins_addr: ins_addr,
                    rs1:      rs1_addr,
                    rs2:      rs2_addr,
                    rd:       rd_addr,
                    op_write: op_write,
                    wb_value: wb_value,
                    mc:       mem_ctrl_t'(mem_ctrl),
                    address:  address,
                    w_data:   w_data
                };
                err <= 1'b0;
                // Register x0 is never read; its value is simply zero.
                if (rs1_addr == 5'd0) rs1_value <= 32'd0;
                if (rs2_addr == 5'd0) rs2_value <= 32'd0;
            end

            if (access_done) begin
                case (state)
                    S_FETCH: ins_data  <= mem.mem_rdata;
                    S_RS1:   rs1_value <= mem.mem_rdata;
                    S_RS2:   rs2_value <= mem.mem_rdata;
                    S_DMEM:  if (req_q.mc == MC_RD) read_data <= mem.mem_rdata;
                    default: ;
                endcase
            end

            // With an illegal mem_ctrl every entry into DONE is the error
            // skip; otherwise only an abandoned access flags an error.
            if ((state != S_DONE) && (state_nxt == S_DONE) &&
                (timeout || (req_q.mc == MC_ERR))) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_seq_initiator.sv
// -----------------------------------------------------------------------------
// tb_mem_seq_initiator
//
// Self-checking bench for mem_seq_initiator. A behavioural memory responds on
// the shared port with a configurable number of wait cycles and logs every
// completed access; a sequence-level reference model predicts the access list,
// the completion cycle and the result registers. Timeout checks are included
// when MEM_SEQ_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_mem_seq_initiator;

    localparam logic [31:0] REG_BASE = 32'h0000_0000;
    localparam int          TIMEOUT  = 15;

    typedef struct {
        logic [31:0] ins_addr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        op_write;
        logic [31:0] wb_value;
        logic [1:0]  mc;
        logic [31:0] address;
        logic [31:0] w_data;
    } req_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cyc_valid = 1'b0;
    logic [31:0] ins_addr = '0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic [4:0]  rd_addr = '0;
    logic        op_write = 1'b0;
    logic [31:0] wb_value = '0;
    logic [1:0]  mem_ctrl = '0;
    logic [31:0] address = '0;
    logic [31:0] w_data = '0;
    logic [31:0] ins_data, rs1_value, rs2_value, read_data;
    logic        cyc_done, busy, err;

    mem_seq_initiator_if mem ();

    mem_seq_initiator #(
        .REG_BASE (REG_BASE),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cyc_valid (cyc_valid),
        .ins_addr  (ins_addr),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rd_addr   (rd_addr),
        .op_write  (op_write),
        .wb_value  (wb_value),
        .mem_ctrl  (mem_ctrl),
        .address   (address),
        .w_data    (w_data),
        .mem       (mem),
        .ins_data  (ins_data),
        .rs1_value (rs1_value),
        .rs2_value (rs2_value),
        .read_data (read_data),
        .cyc_done  (cyc_done),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Deterministic power-up contents shared by the memory and the model.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    // ---------------------------------------------------------------------
    // Behavioural memory: decides mem_ready for the current cycle on the
    // falling edge, logs each access in its completing cycle.
    // ---------------------------------------------------------------------
    logic [31:0] tb_mem [logic [31:0]];
    acc_t        log_q[$];
    int          wait_cycles = 0;
    bit          stall = 1'b0;
    bit          in_acc = 1'b0;
    int          left = 0;
    int          stab_err = 0;
    int          req_cycles = 0;
    acc_t        cap;

    always @(negedge clk) begin
        if (!mem.mem_req) begin
            in_acc        = 1'b0;
            mem.mem_ready = 1'($urandom_range(0, 1));
            mem.mem_rdata = $urandom;
        end else begin
            req_cycles++;
            if (!in_acc) begin
                in_acc    = 1'b1;
                left      = wait_cycles;
                cap.addr  = mem.mem_addr;
                cap.we    = mem.mem_we;
                cap.wdata = mem.mem_wdata;
            end else if (mem.mem_addr !== cap.addr || mem.mem_we !== cap.we ||
                         mem.mem_wdata !== cap.wdata) begin
                stab_err++;
            end
            if (stall || left > 0) begin
                mem.mem_ready = 1'b0;
                mem.mem_rdata = $urandom;
                left--;
            end else begin
                mem.mem_ready = 1'b1;
                mem.mem_rdata = tb_mem.exists(cap.addr) ? tb_mem[cap.addr] : init_word(cap.addr);
                if (cap.we) tb_mem[cap.addr] = cap.wdata;
                log_q.push_back(cap);
                in_acc = 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Reference model: one whole sequence at a time.
    // ---------------------------------------------------------------------
    logic [31:0] ref_mem [logic [31:0]];
    acc_t        exp_q[$];
    logic [31:0] exp_ins = '0, exp_rs1 = '0, exp_rs2 = '0, exp_rd = '0;
    logic        exp_err = 1'b0;

    function automatic logic [31:0] rd_ref(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic push_acc(input logic [31:0] a, input logic we, input logic [31:0] d);
        acc_t e;
        e.addr = a; e.we = we; e.wdata = d;
        exp_q.push_back(e);
        if (we) ref_mem[a] = d;
    endtask

    task automatic model(input req_t r);
        logic [31:0] a;
        exp_q.delete();
        exp_err = 1'b0;
        exp_ins = rd_ref(r.ins_addr);
        push_acc(r.ins_addr, 1'b0, 32'd0);
        exp_rs1 = 32'd0;
        if (r.rs1 != 0) begin
            a = REG_BASE + 32'(r.rs1) * 4;
            exp_rs1 = rd_ref(a);
            push_acc(a, 1'b0, 32'd0);
        end
        exp_rs2 = 32'd0;
        if (r.rs2 != 0) begin
            a = REG_BASE + 32'(r.rs2) * 4;
            exp_rs2 = rd_ref(a);
            push_acc(a, 1'b0, 32'd0);
        end
        if (r.mc == 2'b11) begin
            exp_err = 1'b1;
            return;
        end
        if (r.mc == 2'b10) begin
            exp_rd = rd_ref(r.address);
            push_acc(r.address, 1'b0, 32'd0);
        end else if (r.mc == 2'b01) begin
            push_acc(r.address, 1'b1, r.w_data);
        end
        if (r.op_write && r.rd != 0)
            push_acc(REG_BASE + 32'(r.rd) * 4, 1'b1, r.wb_value);
    endtask

    task automatic apply(input req_t r);
        ins_addr = r.ins_addr; rs1_addr = r.rs1; rs2_addr = r.rs2; rd_addr = r.rd;
        op_write = r.op_write; wb_value = r.wb_value; mem_ctrl = r.mc;
        address = r.address; w_data = r.w_data;
    endtask

    task automatic scramble();
        ins_addr = $urandom; rs1_addr = 5'($urandom); rs2_addr = 5'($urandom);
        rd_addr = 5'($urandom); op_write = 1'($urandom); wb_value = $urandom;
        mem_ctrl = 2'($urandom); address = $urandom; w_data = $urandom;
    endtask

    // Accept a request, then scramble the inputs to prove they were latched.
    task automatic start(input req_t r);
        @(negedge clk);
        check("idle_before_accept", busy, 1'b0);
        apply(r);
        cyc_valid = 1'b1;
        @(posedge clk);
        #1;
        cyc_valid = 1'b0;
        scramble();
    endtask

    task automatic run_seq(input string name, input req_t r, input int waits, input bit inject);
        int done_c;
        done_c = 0;
        wait_cycles = waits;
        stab_err = 0;
        log_q.delete();
        model(r);
        start(r);
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (c == 1) check({name, "_err_cleared"}, err, 1'b0);
            cyc_valid = inject && (c == 2);
            if (cyc_done) begin
                done_c = c;
                break;
            end
        end
        cyc_valid = 1'b0;
        check({name, "_done_cycle"}, done_c, exp_q.size() * (waits + 1) + 1);
        check({name, "_acc_count"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < log_q.size()) begin
                check($sformatf("%s_acc%0d_addr", name, i), log_q[i].addr, exp_q[i].addr);
                check($sformatf("%s_acc%0d_we", name, i), log_q[i].we, exp_q[i].we);
                if (exp_q[i].we)
                    check($sformatf("%s_acc%0d_wdata", name, i), log_q[i].wdata, exp_q[i].wdata);
            end
        end
        check({name, "_ins_data"}, ins_data, exp_ins);
        check({name, "_rs1_value"}, rs1_value, exp_rs1);
        check({name, "_rs2_value"}, rs2_value, exp_rs2);
        check({name, "_read_data"}, read_data, exp_rd);
        check({name, "_err"}, err, exp_err);
        check({name, "_addr_stable"}, stab_err, 0);
        @(negedge clk);
        check({name, "_done_one_cycle"}, cyc_done, 1'b0);
        check({name, "_idle_after"}, busy, 1'b0);
    endtask

    function automatic req_t mk(input logic [31:0] ia, input logic [4:0] r1, input logic [4:0] r2,
                                input logic [1:0] mc, input logic [31:0] ad, input logic [31:0] wd,
                                input logic ow, input logic [4:0] rd, input logic [31:0] wb);
        req_t r;
        r.ins_addr = ia; r.rs1 = r1; r.rs2 = r2; r.mc = mc; r.address = ad;
        r.w_data = wd; r.op_write = ow; r.rd = rd; r.wb_value = wb;
        return r;
    endfunction

    function automatic logic [4:0] rand_reg();
        return ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: observed=expired required=finish");
        $fatal(1, "time limit");
    end

    initial begin
        req_t r;
        bit   found;
        int   done_c;

        // ---------------- reset values ----------------
        repeat (3) @(negedge clk);
        check("rst_mem_req", mem.mem_req, 1'b0);
        check("rst_mem_we", mem.mem_we, 1'b0);
        check("rst_mem_addr", mem.mem_addr, 32'd0);
        check("rst_mem_wdata", mem.mem_wdata, 32'd0);
        check("rst_ins_data", ins_data, 32'd0);
        check("rst_rs1_value", rs1_value, 32'd0);
        check("rst_rs2_value", rs2_value, 32'd0);
        check("rst_read_data", read_data, 32'd0);
        check("rst_cyc_done", cyc_done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        reset_n = 1'b1;

        // Full sequence, zero wait; a cyc_valid while busy must be ignored.
        r = mk(32'h200, 5'd3, 5'd4, 2'b10, 32'h180, 32'h0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        run_seq("full", r, 0, 1'b1);
        check("full_no_queued_start", busy, 1'b0);

        // Fetch only.
        r = mk(32'h040, 5'd0, 5'd0, 2'b00, 32'h0, 32'h0, 1'b1, 5'd0, 32'h1111_2222);
        run_seq("minimal", r, 0, 1'b0);

        // Data write with three wait cycles per access.
        r = mk(32'h044, 5'd0, 5'd0, 2'b01, 32'h100, 32'h1234_5678, 1'b0, 5'd0, 32'h0);
        run_seq("write_wait3", r, 3, 1'b0);

        // Illegal mem_ctrl, then a normal sequence clears err at accept.
        r = mk(32'h048, 5'd2, 5'd0, 2'b11, 32'h0C0, 32'hAAAA_5555, 1'b1, 5'd7, 32'hCAFE_F00D);
        run_seq("mc_err", r, 1, 1'b0);
        r = mk(32'h04C, 5'd7, 5'd0, 2'b00, 32'h0, 32'h0, 1'b1, 5'd8, 32'h0BAD_CAFE);
        run_seq("after_err", r, 0, 1'b0);

        // ---------------- asynchronous reset during RS1 ----------------
        r = mk(32'h050, 5'd3, 5'd0, 2'b00, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        wait_cycles = 3;
        start(r);
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mem.mem_req && mem.mem_addr == REG_BASE + 32'd12) begin
                found = 1'b1;
                break;
            end
        end
        check("rstmid_reached_rs1", found, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("rstmid_mem_req", mem.mem_req, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_cyc_done", cyc_done, 1'b0);
        check("rstmid_ins_data", ins_data, 32'd0);
        exp_ins = '0; exp_rs1 = '0; exp_rs2 = '0; exp_rd = '0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rstmid_quiet%0d", c), {30'd0, busy, cyc_done}, 32'd0);
        end
        r = mk(32'h054, 5'd3, 5'd9, 2'b10, 32'h0A0, 32'h0, 1'b1, 5'd10, 32'h5555_AAAA);
        run_seq("after_rst", r, 2, 1'b0);

        // ---------------- randomized sequences ----------------
        for (int n = 0; n < 24; n++) begin
            r = mk(32'($urandom_range(0, 255)) << 2, rand_reg(), rand_reg(),
                   2'($urandom_range(0, 3)), 32'($urandom_range(0, 255)) << 2, $urandom,
                   1'($urandom_range(0, 1)), rand_reg(), $urandom);
            run_seq($sformatf("rand%0d", n), r, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

`ifdef MEM_SEQ_TIMEOUT_EN
        // ---------------- watchdog: memory never ready during FETCH ----------------
        r = mk(32'h080, 5'd4, 5'd6, 2'b00, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        stall = 1'b1;
        log_q.delete();
        start(r);
        req_cycles = 0;
        done_c = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (cyc_done) begin
                done_c = c;
                break;
            end
        end
        check("tmo_done_cycle", done_c, TIMEOUT + 1);
        check("tmo_req_cycles", req_cycles, TIMEOUT);
        check("tmo_err", err, 1'b1);
        check("tmo_ins_data_kept", ins_data, exp_ins);
        check("tmo_rs1_kept", rs1_value, exp_rs1);
        check("tmo_no_access", log_q.size(), 0);
        stall = 1'b0;
        @(negedge clk);
        check("tmo_idle_after", busy, 1'b0);
        r = mk(32'h084, 5'd1, 5'd0, 2'b10, 32'h0C4, 32'h0, 1'b0, 5'd0, 32'h0);
        run_seq("after_tmo", r, 0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_seq_initiator.md
# mem_seq_initiator

Core-side memory initiator for the RISC-V core. It sequences one instruction's worth of memory traffic (instruction fetch, two register-file reads, one data read or write, one register write-back) onto a single shared word port, and issues each access with a req/ready handshake. The register file lives in the same memory at byte address REG_BASE + 4·index. The block sits between the pipeline control and the unified memory and stalls the core until the whole sequence completes.

## Interface
Parameters:
- REG_BASE, 32'd0, byte base address of the register-file region.
- TIMEOUT, 15, maximum wait cycles per access (used only with the watchdog enabled).

Ports (clock and reset first):
- clk  in  1  single clock for the block.
- reset_n  in  1  asynchronous reset, active-low.
- cyc_valid  in  1  start request; sampled only in IDLE.
- ins_addr  in  32  fetch byte address.
- rs1_addr, rs2_addr  in  5  source register indices.
- rd_addr  in  5  write-back register index.
- op_write  in  1  write-back enable.
- wb_value  in  32  write-back data.
- mem_ctrl  in  2  [1] data read, [0] data write.
- address  in  32  data byte address.
- w_data  in  32  data write value.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write strobe.
- mem_addr  out  32  memory byte address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid while mem_ready=1.
- mem_ready  in  1  access completes on any edge where mem_req=1 and mem_ready=1.
- ins_data, rs1_value, rs2_value, read_data  out  32  registered results.
- cyc_done  out  1  one-cycle completion pulse.
- busy  out  1  high whenever state ≠ IDLE.
- err  out  1  sticky error flag.

## Operation
- FSM states: IDLE → FETCH → RS1 → RS2 → DMEM → WB → DONE → IDLE.
- Accept: cyc_valid=1 in IDLE. All request inputs are latched on that edge, and err is cleared.
- FETCH is always performed: read at ins_addr, result into ins_data.
- RS1 and RS2: read at REG_BASE + {rs,2'b00}. An index of 0 skips the state, makes no access, and forces the value to 0.
- DMEM:
  - mem_ctrl=10: read address into read_data.
  - mem_ctrl=01: write w_data at address.
  - mem_ctrl=00: state skipped.
  - mem_ctrl=11: no access, err=1, jump directly to DONE (WB skipped).
- WB: performed only when op_write=1 and rd≠0. Writes wb_value at REG_BASE + {rd,2'b00}.
- A skipped state costs zero cycles; the FSM computes the next non-skipped state directly.
- mem_req is high only in an access state. mem_we=1 only in a DMEM write or WB. mem_addr/mem_wdata are held stable while mem_req=1.
- Result registers hold their values until overwritten by the next sequence.

## Timing
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, all result registers=0, cyc_done=0, busy=0, err=0, state=IDLE.
- Accept edge at cycle 0. The first access state is cycle 1.
- Each access lasts 1 + wait cycles. A zero-wait memory (mem_ready tied 1) gives 1 cycle per access.
- cyc_done is high for exactly the DONE cycle. The next cyc_valid can be accepted in the cycle after DONE.
- Full sequence with zero-wait memory: cyc_done in cycle 6. Minimal sequence (fetch only): cyc_done in cycle 2.
- mem_ready while mem_req=0 is ignored.
- Asynchronous reset mid-sequence: mem_req drops immediately and the FSM returns to IDLE. Partial results are discarded and reset to 0, and cyc_done is not issued.
- cyc_valid while busy is ignored and not queued.

## Configuration
- MEM_SEQ_TIMEOUT_EN defined: a per-access wait counter is compiled in. It resets on each new access and increments each cycle with mem_req=1 and mem_ready=0. When it reaches TIMEOUT: the access is abandoned, err=1, and the FSM jumps to DONE; result registers not yet written keep their prior values.
- MEM_SEQ_TIMEOUT_EN undefined: there is no counter, accesses wait indefinitely, and err is set only by mem_ctrl=11.

## Structure
- Shared package: state enumeration, mem_ctrl encodings (MC_NONE, MC_WR, MC_RD, MC_ERR), and the register address helper (REG_BASE + index·4).
- One natural sub-module, mem_seq_watchdog: the timeout counter, instantiated only under MEM_SEQ_TIMEOUT_EN.

## Test plan
- Reset mid-RS1 with mem_req=1 → mem_req=0 asynchronously, busy=0, no cyc_done. The next request runs normally.
- Zero-wait memory, ins_addr=0x200, rs1=3, rs2=4, mem_ctrl=10, address=0x180, op_write=1, rd=5, wb_value=0xDEADBEEF:
  - Expected addresses in order: 0x200, 0x00C, 0x010, 0x180, 0x014 (write).
  - cyc_done in cycle 6.
- rs1=0, rs2=0, mem_ctrl=00, op_write=1, rd=0 → only the fetch access is issued, rs1_value=rs2_value=0, cyc_done in cycle 2.
- Memory inserting 3 wait cycles on every access, mem_ctrl=01, address=0x100, w_data=0x12345678 → single write with mem_we=1, mem_wdata=0x12345678. Address and data are stable for 4 cycles.
- mem_ctrl=11 → no DMEM or WB access, err=1 in DONE, and err is cleared at the next accept.
- With MEM_SEQ_TIMEOUT_EN and TIMEOUT=15, mem_ready held 0 during FETCH → mem_req drops after 15 wait cycles, err=1, cyc_done pulses, ins_data is unchanged.
